// File: rtl/io_input_cond.sv
// Board input conditioner: 2-flop synchronizers, per-button debounce, press pulses
// and write-one-to-clear sticky flags. Optional press interrupt via IO_IRQ_EN.
module io_input_cond #(
  parameter int unsigned NUM_SW          = 32,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BTN_ACTIVE_LOW  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SW-1:0]  i_io_sw,
  input  logic [NUM_BTN-1:0] i_io_btn,
  output logic [NUM_SW-1:0]  o_sw,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_btn_press,
  output logic [NUM_BTN-1:0] o_btn_sticky,
  input  logic               i_clr_we,
  input  logic [NUM_BTN-1:0] i_clr_mask
`ifdef IO_IRQ_EN
  ,
  output logic               o_irq
`endif
);

  localparam int unsigned        CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BTN-1:0] BTN_INV = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_SW-1:0]           r_sw_s1;
  logic [NUM_SW-1:0]           r_sw_s2;
  logic [NUM_BTN-1:0]          r_btn_s1;
  logic [NUM_BTN-1:0]          r_btn_s2;
  logic [NUM_BTN-1:0][CW-1:0]  r_cnt;
  logic [NUM_BTN-1:0]          r_level;
  logic [NUM_BTN-1:0]          r_press;
  logic [NUM_BTN-1:0]          r_sticky;

  logic [NUM_BTN-1:0]          w_b;
  logic [NUM_BTN-1:0][CW-1:0]  w_cnt_nxt;
  logic [NUM_BTN-1:0]          w_level_nxt;
  logic [NUM_BTN-1:0]          w_press_nxt;
  logic [NUM_BTN-1:0]          w_clr;
  logic [NUM_BTN-1:0]          w_sticky_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= i_io_sw;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= i_io_btn;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Press and sticky are computed from the next level so they rise with it.
  always_comb begin
    w_b         = r_btn_s2 ^ BTN_INV;
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (w_b[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_level_nxt[i] = w_b[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
    w_press_nxt  = w_level_nxt & ~r_level;
    w_clr        = i_clr_we ? i_clr_mask : '0;
    w_sticky_nxt = (r_sticky & ~w_clr) | w_press_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_level  <= '0;
      r_press  <= '0;
      r_sticky <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_level  <= w_level_nxt;
      r_press  <= w_press_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign o_sw         = r_sw_s2;
  assign o_btn_level  = r_level;
  assign o_btn_press  = r_press;
  assign o_btn_sticky = r_sticky;

`ifdef IO_IRQ_EN
  logic r_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |r_sticky;
    end
  end

  assign o_irq = r_irq;
`endif

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond: one active-high and one active-low instance,
// both with a 4-cycle debounce.
module tb_io_input_cond;

  localparam int D = 4;

  typedef struct {
    logic [31:0] sw;
    logic [31:0] e1;
    logic [31:0] e2;
  } sw_vec_t;

  typedef struct {
    logic       we;
    logic [3:0] mask;
    logic [3:0] exp;
  } clr_vec_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] sw_a;
  logic [3:0]  btn_a, btn_b;
  logic        clr_we_a, clr_we_b;
  logic [3:0]  clr_mask_a, clr_mask_b;
  logic [31:0] osw_a, osw_b;
  logic [3:0]  lvl_a, prs_a, stk_a;
  logic [3:0]  lvl_b, prs_b, stk_b;
`ifdef IO_IRQ_EN
  logic        irq_a, irq_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  io_input_cond #(.NUM_SW(32), .NUM_BTN(4), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(0)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_io_sw(sw_a), .i_io_btn(btn_a),
    .o_sw(osw_a), .o_btn_level(lvl_a), .o_btn_press(prs_a), .o_btn_sticky(stk_a),
    .i_clr_we(clr_we_a), .i_clr_mask(clr_mask_a)
`ifdef IO_IRQ_EN
    , .o_irq(irq_a)
`endif
  );

  io_input_cond #(.NUM_SW(32), .NUM_BTN(4), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_io_sw(32'h0), .i_io_btn(btn_b),
    .o_sw(osw_b), .o_btn_level(lvl_b), .o_btn_press(prs_b), .o_btn_sticky(stk_b),
    .i_clr_we(clr_we_b), .i_clr_mask(clr_mask_b)
`ifdef IO_IRQ_EN
    , .o_irq(irq_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_a_zero(input string nm);
    chk({nm, " sw"}, osw_a, 32'h0);
    chk({nm, " lvl/prs/stk"}, {20'h0, lvl_a, prs_a, stk_a}, 32'h0);
`ifdef IO_IRQ_EN
    chk({nm, " irq"}, {31'h0, irq_a}, 32'h0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1);
  end

  initial begin
    sw_vec_t    sw_tab [4];
    clr_vec_t   clr_tab[4];
    logic [13:0] glitch;

    sw_tab[0] = '{sw: 32'hA5A5_0F0F, e1: 32'hFFFF_FFFF, e2: 32'hA5A5_0F0F};
    sw_tab[1] = '{sw: 32'h0000_0000, e1: 32'hA5A5_0F0F, e2: 32'h0000_0000};
    sw_tab[2] = '{sw: 32'hDEAD_BEEF, e1: 32'h0000_0000, e2: 32'hDEAD_BEEF};
    sw_tab[3] = '{sw: 32'h8000_0001, e1: 32'hDEAD_BEEF, e2: 32'h8000_0001};

    clr_tab[0] = '{we: 1'b1, mask: 4'b0101, exp: 4'b1010};
    clr_tab[1] = '{we: 1'b0, mask: 4'b1111, exp: 4'b1010};
    clr_tab[2] = '{we: 1'b1, mask: 4'b1000, exp: 4'b0010};
    clr_tab[3] = '{we: 1'b1, mask: 4'b0010, exp: 4'b0000};

    glitch = 14'b00_0000_0111_0111;

    rst_a = 1'b0; rst_b = 1'b0;
    sw_a = 32'hFFFF_FFFF;
    btn_a = 4'h0; btn_b = 4'hF;
    clr_we_a = 1'b0; clr_mask_a = 4'h0;
    clr_we_b = 1'b0; clr_mask_b = 4'h0;
    #1;
    chk_a_zero("reset t0");

    for (int i = 0; i < 4; i++) begin
      step();
      chk_a_zero("reset hold");
    end
    chk("reset b lvl/stk", {24'h0, lvl_b, stk_b}, 32'h0);

    rst_a = 1'b1; rst_b = 1'b1;
    step();
    chk("sw after rel e1", osw_a, 32'h0);
    step();
    chk("sw after rel e2", osw_a, 32'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      sw_a = sw_tab[i].sw;
      step();
      chk("sw lat1", osw_a, sw_tab[i].e1);
      step();
      chk("sw lat2", osw_a, sw_tab[i].e2);
    end
    chk("b idle no press", {24'h0, lvl_b, stk_b}, 32'h0);
    chk("b sw", osw_b, 32'h0);

    // Clean press on btn[0]
    btn_a = 4'b0001;
    for (int e = 1; e < 6; e++) begin
      step();
      chk("press pre lvl/prs", {28'h0, lvl_a[0], prs_a[0]}, 32'h0);
    end
    step();
    chk("press e6 lvl", {28'h0, lvl_a}, 32'h1);
    chk("press e6 prs", {28'h0, prs_a}, 32'h1);
    chk("press e6 stk", {28'h0, stk_a}, 32'h1);
`ifdef IO_IRQ_EN
    chk("irq e6", {31'h0, irq_a}, 32'h0);
`endif
    step();
    chk("press e7 prs", {28'h0, prs_a}, 32'h0);
    chk("press e7 lvl/stk", {24'h0, lvl_a, stk_a}, 32'h11);
`ifdef IO_IRQ_EN
    chk("irq e7", {31'h0, irq_a}, 32'h1);
`endif
    for (int e = 0; e < 3; e++) begin
      step();
      chk("held no repress", {28'h0, prs_a}, 32'h0);
    end

    btn_a = 4'b0000;
    for (int e = 1; e < 6; e++) begin
      step();
      chk("release pre", {24'h0, lvl_a, prs_a}, 32'h10);
    end
    step();
    chk("release e6", {24'h0, lvl_a, prs_a}, 32'h0);
    chk("release stk kept", {28'h0, stk_a}, 32'h1);

    clr_we_a = 1'b1; clr_mask_a = 4'b0001;
    step();
    clr_we_a = 1'b0; clr_mask_a = 4'b0000;
    chk("clr bit0 stk", {28'h0, stk_a}, 32'h0);
`ifdef IO_IRQ_EN
    chk("irq hold after clr", {31'h0, irq_a}, 32'h1);
    step();
    chk("irq drop", {31'h0, irq_a}, 32'h0);
`endif

    // Glitch rejection on btn[1]
    for (int i = 0; i < 14; i++) begin
      btn_a[1] = glitch[i];
      step();
      chk("glitch btn1", {29'h0, lvl_a[1], prs_a[1], stk_a[1]}, 32'h0);
    end

    // Sticky clear table
    btn_a = 4'hF;
    for (int e = 0; e < 6; e++) step();
    chk("all press prs", {28'h0, prs_a}, 32'hF);
    chk("all press stk", {28'h0, stk_a}, 32'hF);
    btn_a = 4'h0;
    for (int e = 0; e < 8; e++) step();
    chk("all released lvl", {28'h0, lvl_a}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      clr_we_a = clr_tab[i].we; clr_mask_a = clr_tab[i].mask;
      step();
      clr_we_a = 1'b0; clr_mask_a = 4'h0;
      chk("clr table stk", {28'h0, stk_a}, {28'h0, clr_tab[i].exp});
    end

    // Set/clear collision on bit 1
    btn_a = 4'b0010;
    for (int e = 0; e < 5; e++) step();
    clr_we_a = 1'b1; clr_mask_a = 4'b0010;
    step();
    chk("collide prs", {28'h0, prs_a}, 32'h2);
    chk("collide stk", {28'h0, stk_a}, 32'h2);
    step();
    clr_we_a = 1'b0; clr_mask_a = 4'h0;
    chk("post collide clr", {28'h0, stk_a}, 32'h0);
    btn_a = 4'h0;
    for (int e = 0; e < 8; e++) step();
    chk("idle lvl", {28'h0, lvl_a}, 32'h0);

    // Reset in the middle of a debounce count
    btn_a = 4'b0001;
    for (int e = 0; e < 4; e++) step();
    chk("mid count lvl", {28'h0, lvl_a}, 32'h0);
    rst_a = 1'b0;
    #1;
    chk_a_zero("async reset");
    step();
    step();
    rst_a = 1'b1;
    for (int e = 1; e < 6; e++) begin
      step();
      chk("post reset pre lvl", {28'h0, lvl_a}, 32'h0);
    end
    step();
    chk("post reset lvl", {28'h0, lvl_a}, 32'h1);
    chk("post reset prs", {28'h0, prs_a}, 32'h1);

    // Active-low instance: btn[2] pulled low
    btn_b = 4'b1011;
    for (int e = 1; e < 6; e++) begin
      step();
      chk("al pre lvl", {28'h0, lvl_b}, 32'h0);
    end
    step();
    chk("al lvl", {28'h0, lvl_b}, 32'h4);
    chk("al prs", {28'h0, prs_b}, 32'h4);
    chk("al stk", {28'h0, stk_b}, 32'h4);
    step();
    chk("al prs end", {28'h0, prs_b}, 32'h0);
`ifdef IO_IRQ_EN
    chk("al irq", {31'h0, irq_b}, 32'h1);
`endif
    btn_b = 4'hF;
    for (int e = 1; e < 6; e++) step();
    chk("al rel pre", {28'h0, lvl_b}, 32'h4);
    step();
    chk("al rel lvl", {24'h0, lvl_b, prs_b}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_cond.md
Name: io_input_cond

Overview:
- Input-side conditioner for the board I/O interface: the counterpart to the CPU's LED/HEX/LCD output path.
- Takes raw asynchronous switch and button pins, synchronizes them to `i_clk`, and debounces the buttons.
- Produces single-cycle press pulses and sticky, write-one-to-clear press flags.
- Sits between the top-level pins and the `singlecycle` core's `i_io_sw`/`i_io_btn` inputs, and feeds the LSU input-peripheral read mux.

Parameters:
- NUM_SW, 32, number of switch inputs.
- NUM_BTN, 4, number of button inputs.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a button level change is accepted (5 ms at 100 MHz); legal range 1..2^24-1.
- BTN_ACTIVE_LOW, 0, when 1 raw buttons are inverted after synchronization, so that 1 always means pressed.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_io_sw  input  NUM_SW  raw switch pins, asynchronous.
- i_io_btn  input  NUM_BTN  raw button pins, asynchronous.
- o_sw  output  NUM_SW  synchronized switch levels.
- o_btn_level  output  NUM_BTN  debounced button level, 1 = pressed.
- o_btn_press  output  NUM_BTN  one-cycle pulse on debounced 0->1 transition.
- o_btn_sticky  output  NUM_BTN  latched press flags.
- i_clr_we  input  1  clear strobe for sticky flags.
- i_clr_mask  input  NUM_BTN  write-one-to-clear mask, sampled when i_clr_we=1.
- o_irq  output  1  press interrupt (present only with IO_IRQ_EN).

Behaviour:
- Reset (async, `i_rst_n`=0) clears immediately:
  - all synchronizer flops,
  - o_sw=0, o_btn_level=0, o_btn_press=0, o_btn_sticky=0,
  - all debounce counters=0,
  - o_irq=0.
- Reset asserted mid-debounce discards the partial count.
- After release, a button held pressed is reported only after a full debounce interval.
- Synchronizer:
  - two flops per bit on every sw and btn input.
  - A raw change present before edge k appears at the synchronizer output after edge k+1.
- Switches: o_sw = synchronizer output, registered. Total latency 2 cycles, no debounce.
- Buttons, per bit independently:
  - b = sync output, XOR BTN_ACTIVE_LOW.
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
  - If b == o_btn_level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: o_btn_level <= b, counter <= 0.
  - Else: counter <= counter+1.
  - A single-cycle glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches o_btn_level.
  - Level latency from a clean raw edge: 2 + DEBOUNCE_CYCLES cycles.
- Press pulse:
  - o_btn_press[i] is registered and high for exactly the cycle in which o_btn_level[i] first reads 1 after reading 0.
  - It is never asserted on a release.
  - It is never asserted twice for one press.
- Sticky flags:
  - The set condition is the registered next value of o_btn_press[i], so o_btn_sticky[i] rises in the same cycle as o_btn_press[i].
  - Clear occurs on an edge with i_clr_we=1 and i_clr_mask[i]=1.
  - If set and clear coincide for the same bit, set wins and the flag stays 1.
  - i_clr_mask is ignored when i_clr_we=0.
  - Bits with mask 0 are unaffected.
- No state machine beyond the per-bit counter and level registers; all outputs are registers, with no combinational input-to-output path.

Optional Feature:
- Macro IO_IRQ_EN.
- Defined:
  - o_irq port exists.
  - o_irq is a registered OR-reduction of o_btn_sticky: it asserts one cycle after any sticky bit sets.
  - It deasserts one cycle after the last sticky bit clears.
- Undefined: o_irq port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and switches:
  - Stimulus: hold i_rst_n=0 for 4 cycles with i_io_sw=32'hFFFF_FFFF; release; then drive i_io_sw=32'hA5A5_0F0F at cycle k.
  - Response: all outputs are 0 during reset; o_sw=32'hA5A5_0F0F exactly 2 cycles after cycle k.
- Clean press (DEBOUNCE_CYCLES=4):
  - Stimulus: i_io_btn[0] goes 0->1 and is held.
  - Response: o_btn_level[0]=1 at cycle 6; o_btn_press[0] is high for exactly that one cycle; o_btn_sticky[0]=1 from then on.
  - Release: o_btn_level[0]=0 six cycles after release, with no press pulse.
- Glitch rejection (DEBOUNCE_CYCLES=4):
  - Stimulus: btn[1] pulses high for 3 cycles, low for 1 cycle, high for 3 cycles.
  - Response: o_btn_level[1], o_btn_press[1] and o_btn_sticky[1] stay 0 throughout.
- Sticky clear and collision:
  - Stimulus: set sticky[3:0]=4'b1111; pulse i_clr_we with mask 4'b0101.
  - Response: sticky=4'b1010.
  - Stimulus: clear bit 1 on the same edge that bit 1 pulses press.
  - Response: sticky[1] stays 1.
- Active-low and reset mid-debounce:
  - Stimulus: BTN_ACTIVE_LOW=1, raw btn=4'hF idle, raw btn[2]=0 held.
  - Response: level[2]=1 after 2+4 cycles.
  - Stimulus: assert reset at cycle 4 of a count.
  - Response: level stays 0 and the count restarts from 0 after release.
- IRQ (IO_IRQ_EN defined):
  - Stimulus: press btn[0].
  - Response: o_irq=1 one cycle after sticky[0] sets; clearing mask 4'b0001 drops o_irq one cycle later.
